// File: rtl/wide_add_sequencer_if.sv
// Request/result bundle for wide_add_sequencer: requester drives start/operands, the sequencer returns busy/done/sum/cout.
// With WIDE_ADD_SUB_EN defined, an extra sub request bit selects A - B.
interface wide_add_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
);
  logic                   start;
  logic [WORDS*WIDTH-1:0] a;
  logic [WORDS*WIDTH-1:0] b;
  logic                   cin;
`ifdef WIDE_ADD_SUB_EN
  logic                   sub;
`endif
  logic                   busy;
  logic                   done;
  logic [WORDS*WIDTH-1:0] sum;
  logic                   cout;
  logic                   dbg_state;

  // Handshake: start is a request honoured only while busy=0 (state IDLE); done is a
  // one-cycle valid for sum/cout, and the requester is always ready to take it.
  modport master (
`ifdef WIDE_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, dbg_state
  );

  modport slave (
`ifdef WIDE_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, dbg_state
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: one WIDTH-bit slice reused over WORDS cycles with carry chained between words.
// Optional subtract mode under macro WIDE_ADD_SUB_EN (B inverted, initial carry forced to 1).
module wide_add_sequencer #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OP_W  = WORDS * WIDTH;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]   partial_q, partial_d;
  logic [OP_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cout_q, cout_d;

  logic [WIDTH-1:0]  a_word;
  logic [WIDTH-1:0]  b_word;
  logic [WIDTH:0]    slice;
  logic              b_inv;
  logic              carry_init;

  always_comb begin
    b_inv      = 1'b0;
    carry_init = bus.cin;
`ifdef WIDE_ADD_SUB_EN
    if (bus.sub) begin
      b_inv      = 1'b1;
      carry_init = 1'b1;
    end
`endif

    a_word = a_q[idx_q*WIDTH +: WIDTH];
    b_word = b_q[idx_q*WIDTH +: WIDTH];
    // Carry-out of the slice lands in the extra top bit.
    slice  = {1'b0, a_word} + {1'b0, b_word} + {{WIDTH{1'b0}}, carry_q};

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cout_d    = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_inv ? ~bus.b : bus.b;
          carry_d = carry_init;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        partial_d[idx_q*WIDTH +: WIDTH] = slice[WIDTH-1:0];
        carry_d = slice[WIDTH];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          sum_d   = partial_d;
          cout_d  = slice[WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.dbg_state = state_q;
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-precision adder controller. It adds two WORDS*WIDTH-bit operands by time-sharing one WIDTH-bit adder slice over WORDS clock cycles, chaining the carry between words. It sits between a requester issuing start/operand commands and the shared adder datapath. It gives wide additions without instantiating a wide adder.

Parameters:
WIDTH, 4, bit width of the shared adder slice (>=1)
WORDS, 4, number of slices per operation (>=1); operand width = WORDS*WIDTH
IDX_W, $clog2(WORDS) min 1, word-index counter width (localparam)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  request; sampled only while state is IDLE
a  in  WORDS*WIDTH  operand A; word i = a[i*WIDTH +: WIDTH]
b  in  WORDS*WIDTH  operand B, same slicing
cin  in  1  initial carry into word 0
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse; result valid
sum  out  WORDS*WIDTH  registered result; held until the next completion
cout  out  1  registered carry out of the top word

Behaviour:
- Reset (rst=0, async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; operand, carry, index and partial-result registers cleared. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, ADD.
- IDLE:
  - done is forced to 0 on every edge except the completion edge.
  - At edge E0 with start=1: capture a, b into operand registers; carry<=cin; idx<=0; busy<=1; state<=ADD.
  - start=0: remain IDLE.
- ADD, at each edge:
  - {c, w} = A_word[idx] + B_word[idx] + carry, computed at WIDTH+1 bits with no truncation of c.
  - partial[idx] <= w; carry <= c; idx <= idx+1.
- Completion, at the edge where idx==WORDS-1:
  - sum <= partial with the top word replaced by w; cout <= c.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: start sampled at E0; result and done visible after edge E_WORDS, i.e. WORDS cycles. done is high exactly one cycle.
- Input sampling:
  - start while busy=1 is ignored; no queueing.
  - Changes on a/b/cin after E0 do not affect the running operation.
- Back-to-back: start=1 in the cycle done=1 (state IDLE) is accepted. The next result follows WORDS cycles later, so throughput is one operation per WORDS+1 cycles.
- WORDS=1: a single ADD cycle, which behaves as a registered WIDTH-bit adder with 1-cycle latency.
- Wrap-around: the sum is modulo 2^(WORDS*WIDTH); overflow is reported only via cout.
- sum/cout hold their last result while IDLE and while busy, until the next completion.

Optional Feature:
Macro WIDE_ADD_SUB_EN.
- Defined:
  - Extra port sub (in, 1), sampled with start at E0.
  - sub=1: the operation is A - B, i.e. B is captured bit-inverted and the initial carry is forced to 1 (cin ignored).
  - cout=1 means no borrow (A>=B unsigned).
  - sub=0 behaves as plain add.
- Not defined: no sub port; addition only.

Test Plan:
- WIDTH=4, WORDS=4: reset then a=16'hFFFF, b=16'h0001, cin=0, start pulse -> carry ripples through all words; after 4 cycles sum=16'h0000, cout=1, done=1 for one cycle, busy high exactly 4 cycles.
- a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0 after 4 cycles; sum holds 16'h5556 for 10 idle cycles.
- Busy-ignore and back-to-back: first op a=16'h00FF, b=16'h0001 (start) -> sum=16'h0100, cout=0; pulse start mid-op with a=16'h1111, b=16'h1111 -> ignored, only one done; then hold start=1 in the done cycle with a=16'hFFFF, b=16'hFFFF, cin=1 -> second result sum=16'hFFFF, cout=1, exactly 5 cycles after the first done.
- Reset mid-op: start, then drop rst at cycle 2 -> busy=0, done=0, sum=0, cout=0 immediately (asynchronously); no done after release.
- Randomized: 20 random a/b/cin ops -> {cout,sum} == a+b+cin on every done; also repeat with WORDS=1, WIDTH=8.
- WIDE_ADD_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0; a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
